// File: rtl/viterbi_pkg.sv
// Shared constants and helpers for the rate-1/2, K=3 convolutional codec.
// Holds the trellis shape, generator polynomials, metric start/normalization
// constants and the expected-symbol function used by both encoder and decoder.
package viterbi_pkg;

  localparam int unsigned K          = 3;
  localparam int unsigned NUM_STATES = 2 ** (K - 1);

  // Generator taps applied to {d, s1, s0}.
  localparam logic [2:0] G1 = 3'b111;
  localparam logic [2:0] G0 = 3'b101;

  // States 1..3 start penalised so decoding begins in state 0.
  localparam int unsigned INIT_METRIC = 8;
  // Amount removed from every metric once all four reach it.
  localparam int unsigned NORM_METRIC = 4;

  // Coded symbol {g1,g0} produced when bit b enters a coder in state {s1,s0}.
  function automatic logic [1:0] expected_symbol(input logic [1:0] state, input logic b);
    logic [2:0] taps;
    taps = {b, state};
    return {^(taps & G1), ^(taps & G0)};
  endfunction

endpackage

// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder with a one-cycle registered output.
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset
//   enable_i - accept d_i this cycle
//   d_i      - information bit
//   valid_o  - sym_o holds a fresh symbol (registered enable_i)
//   sym_o    - coded symbol {g1,g0}; holds while not enabled
module conv_encoder
  import viterbi_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       d_i,
  output logic       valid_o,
  output logic [1:0] sym_o
);

  // state_q = {previous bit, bit before that}
  logic [1:0] state_q, state_d;
  logic [1:0] sym_q, sym_d;
  logic       valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    valid_d = enable_i;
    if (enable_i) begin
      sym_d   = expected_symbol(state_q, d_i);
      state_d = {d_i, state_q[1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '0;
      sym_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign sym_o   = sym_q;

endmodule

// File: rtl/viterbi_codec.sv
// Convolutional encoder plus hard-decision 4-state register-exchange Viterbi
// decoder. Encode and decode paths are fully independent.
// Ports:
//   clk, rst (async, active low)
//   enc_enable_i/enc_d_i  -> enc_valid_o/enc_d_o   (1-cycle latency)
//   dec_enable_i/dec_d_i  -> dec_valid_o/dec_d_o   (TB_DEPTH enabled symbols)
module viterbi_codec
  import viterbi_pkg::*;
#(
  parameter int unsigned TB_DEPTH = 16,
  parameter int unsigned METRIC_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_i,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_o,
  input  logic       dec_enable_i,
  input  logic [1:0] dec_d_i,
  output logic       dec_valid_o,
  output logic       dec_d_o
);

  localparam int unsigned CntW = $clog2(TB_DEPTH + 1);
  localparam logic [METRIC_W-1:0] MetricMax  = {METRIC_W{1'b1}};
  localparam logic [METRIC_W-1:0] MetricInit = METRIC_W'(INIT_METRIC);
  localparam logic [METRIC_W-1:0] MetricNorm = METRIC_W'(NORM_METRIC);

  conv_encoder u_enc (
    .clk_i    (clk),
    .rst_ni   (rst),
    .enable_i (enc_enable_i),
    .d_i      (enc_d_i),
    .valid_o  (enc_valid_o),
    .sym_o    (enc_d_o)
  );

  // Survivors keep TB_DEPTH-1 bits; the oldest bit of the freshly exchanged
  // TB_DEPTH-bit path is the decision, so it never needs to be stored.
  logic [METRIC_W-1:0] metric_q   [NUM_STATES];
  logic [METRIC_W-1:0] metric_d   [NUM_STATES];
  logic [METRIC_W-1:0] acs_metric [NUM_STATES];
  logic [METRIC_W-1:0] nrm_metric [NUM_STATES];
  logic [TB_DEPTH-2:0] path_q     [NUM_STATES];
  logic [TB_DEPTH-2:0] path_d     [NUM_STATES];
  logic [TB_DEPTH-1:0] acs_path   [NUM_STATES];
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                dec_d_q, dec_d_d;
  logic                dec_valid_q, dec_valid_d;
  logic [1:0]          best;
  logic                norm;

  // State {s1,s0} is reached from {s0,0} or {s0,1} with input bit s1.
  for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
    localparam logic [1:0] St    = 2'(s);
    localparam logic [1:0] Pred0 = {St[0], 1'b0};
    localparam logic [1:0] Pred1 = {St[0], 1'b1};
    logic [1:0]          x0, x1, bm0, bm1;
    logic [METRIC_W:0]   sum0, sum1;
    logic [METRIC_W-1:0] cand0, cand1;
    logic                take1;

    assign x0    = dec_d_i ^ expected_symbol(Pred0, St[1]);
    assign x1    = dec_d_i ^ expected_symbol(Pred1, St[1]);
    assign bm0   = {1'b0, x0[1]} + {1'b0, x0[0]};
    assign bm1   = {1'b0, x1[1]} + {1'b0, x1[0]};
    assign sum0  = {1'b0, metric_q[Pred0]} + (METRIC_W + 1)'(bm0);
    assign sum1  = {1'b0, metric_q[Pred1]} + (METRIC_W + 1)'(bm1);
    assign cand0 = sum0[METRIC_W] ? MetricMax : sum0[METRIC_W-1:0];
    assign cand1 = sum1[METRIC_W] ? MetricMax : sum1[METRIC_W-1:0];
    // Strict compare: ties keep the s0=0 predecessor.
    assign take1 = cand1 < cand0;
    assign acs_metric[s] = take1 ? cand1 : cand0;
    assign acs_path[s]   = take1 ? {path_q[Pred1], St[1]} : {path_q[Pred0], St[1]};
  end

  always_comb begin
    norm = 1'b1;
    for (int i = 0; i < NUM_STATES; i++) begin
      if (acs_metric[i] < MetricNorm) norm = 1'b0;
    end
    for (int i = 0; i < NUM_STATES; i++) begin
      nrm_metric[i] = norm ? acs_metric[i] - MetricNorm : acs_metric[i];
    end
  end

  // Best state from pre-update metrics; lowest index wins ties.
  always_comb begin
    best = '0;
    for (int i = 1; i < NUM_STATES; i++) begin
      if (metric_q[i] < metric_q[best]) best = 2'(i);
    end
  end

  always_comb begin
    metric_d    = metric_q;
    path_d      = path_q;
    cnt_d       = cnt_q;
    dec_d_d     = dec_d_q;
    dec_valid_d = 1'b0;
    if (dec_enable_i) begin
      metric_d = nrm_metric;
      for (int i = 0; i < NUM_STATES; i++) begin
        path_d[i] = acs_path[i][TB_DEPTH-2:0];
      end
      cnt_d       = (cnt_q == CntW'(TB_DEPTH)) ? cnt_q : cnt_q + CntW'(1);
      dec_d_d     = acs_path[best][TB_DEPTH-1];
      dec_valid_d = (cnt_d == CntW'(TB_DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        metric_q[i] <= (i == 0) ? '0 : MetricInit;
        path_q[i]   <= '0;
      end
      cnt_q       <= '0;
      dec_d_q     <= 1'b0;
      dec_valid_q <= 1'b0;
    end else begin
      metric_q    <= metric_d;
      path_q      <= path_d;
      cnt_q       <= cnt_d;
      dec_d_q     <= dec_d_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  assign dec_d_o     = dec_d_q;
  assign dec_valid_o = dec_valid_q;

endmodule

// File: tb/tb_viterbi_codec.sv
// Directed bench for viterbi_codec: encoder vector, loopback streams with
// clean, single-error, burst-error and enable-gap channels, and async reset.
module tb_viterbi_codec;

  localparam int unsigned TbDepth = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enc_enable_i = 1'b0;
  logic       enc_d_i = 1'b0;
  logic       enc_valid_o;
  logic [1:0] enc_d_o;
  logic       dec_enable_i = 1'b0;
  logic [1:0] dec_d_i = 2'b00;
  logic       dec_valid_o;
  logic       dec_d_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  viterbi_codec #(
    .TB_DEPTH (TbDepth),
    .METRIC_W (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_enable_i),
    .enc_d_i      (enc_d_i),
    .enc_valid_o  (enc_valid_o),
    .enc_d_o      (enc_d_o),
    .dec_enable_i (dec_enable_i),
    .dec_d_i      (dec_d_i),
    .dec_valid_o  (dec_valid_o),
    .dec_d_o      (dec_d_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    enc_enable_i = 1'b0;
    enc_d_i      = 1'b0;
    dec_enable_i = 1'b0;
    dec_d_i      = 2'b00;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {3'b0, enc_valid_o, enc_d_o, dec_valid_o, dec_d_o}, 8'h00);
    rst = 1'b1;
  endtask

  // mode: 0 clean, 1 single g0 errors every 16 symbols, 2 two-symbol bursts
  // every 48 symbols, 3 random enable gaps of 1..5 cycles.
  task automatic run_stream(input int nbits, input int mode);
    bit         data_q[$];
    logic [1:0] st;
    logic [1:0] sym_q;
    logic [1:0] exp_sym;
    logic       b;
    logic       err;
    logic       prev_dec;
    logic [1:0] prev_enc;
    int         gl;
    st    = 2'b00;
    sym_q = 2'b00;
    for (int k = 0; k <= nbits; k++) begin
      b = (k < nbits) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (mode == 3 && k > 0 && $urandom_range(0, 7) == 0) begin
        gl           = $urandom_range(1, 5);
        prev_dec     = dec_d_o;
        prev_enc     = enc_d_o;
        enc_enable_i = 1'b0;
        dec_enable_i = 1'b0;
        repeat (gl) begin
          @(posedge clk);
          #1;
          check("gap_enc_valid", {7'b0, enc_valid_o}, 8'h00);
          check("gap_enc_hold", {6'b0, enc_d_o}, {6'b0, prev_enc});
          check("gap_dec_valid", {7'b0, dec_valid_o}, 8'h00);
          check("gap_dec_hold", {7'b0, dec_d_o}, {7'b0, prev_dec});
        end
      end
      enc_enable_i = (k < nbits);
      enc_d_i      = b;
      dec_enable_i = (k > 0);
      dec_d_i      = sym_q;
      if (k < nbits) data_q.push_back(b);
      @(posedge clk);
      #1;
      if (k < nbits) begin
        exp_sym = {b ^ st[1] ^ st[0], b ^ st[0]};
        st      = {b, st[1]};
        check("loop_enc_valid", {7'b0, enc_valid_o}, 8'h01);
        check("loop_enc_sym", {6'b0, enc_d_o}, {6'b0, exp_sym});
        err = (mode == 1 && (k % 16) == 7) ||
              (mode == 2 && ((k % 48) == 20 || (k % 48) == 21));
        sym_q = enc_d_o ^ {1'b0, err};
      end
      if (k > 0) begin
        if (k >= TbDepth) begin
          check("dec_valid", {7'b0, dec_valid_o}, 8'h01);
          check("dec_bit", {7'b0, dec_d_o}, {7'b0, data_q[k-TbDepth]});
        end else begin
          check("dec_not_valid", {7'b0, dec_valid_o}, 8'h00);
        end
      end
    end
    enc_enable_i = 1'b0;
    dec_enable_i = 1'b0;
  endtask

  logic [1:0] enc_exp [6];
  logic       enc_bits [6];

  initial begin
    enc_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    enc_exp  = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};

    // Encoder directed vector.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      enc_enable_i = 1'b1;
      enc_d_i      = enc_bits[i];
      @(posedge clk);
      #1;
      check("enc_valid", {7'b0, enc_valid_o}, 8'h01);
      check("enc_sym", {6'b0, enc_d_o}, {6'b0, enc_exp[i]});
      check("dec_idle", {7'b0, dec_valid_o}, 8'h00);
    end
    enc_enable_i = 1'b0;
    @(posedge clk);
    #1;
    check("enc_idle_valid", {7'b0, enc_valid_o}, 8'h00);
    check("enc_idle_hold", {6'b0, enc_d_o}, 8'h03);

    do_reset();
    run_stream(256, 0);
    do_reset();
    run_stream(256, 1);
    do_reset();
    run_stream(256, 2);
    do_reset();
    run_stream(200, 3);

    // Async reset between edges with both paths active.
    enc_enable_i = 1'b1;
    enc_d_i      = 1'b1;
    dec_enable_i = 1'b1;
    dec_d_i      = 2'b11;
    @(posedge clk);
    #1;
    check("pre_reset_valid", {6'b0, enc_valid_o, dec_valid_o}, 8'h03);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", {3'b0, enc_valid_o, enc_d_o, dec_valid_o, dec_d_o}, 8'h00);
    enc_enable_i = 1'b0;
    dec_enable_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_stream(128, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/viterbi_codec.md
Name: viterbi_codec

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder plus hard-decision 4-state Viterbi decoder, in one block with independent encode and decode paths.
- Used as the transmit/receive endpoints of the channel-error-injection environment.
- The encoder output is registered externally (optionally corrupted) and fed back into the decoder input one cycle later.

Parameters:
- TB_DEPTH, 16: survivor (register-exchange) path length; decode latency in enabled symbols.
- METRIC_W, 6: path-metric width in bits, unsigned, saturating.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- enc_enable_i  in  1  encoder accepts enc_d_i this cycle
- enc_d_i  in  1  information bit
- enc_valid_o  out  1  enc_d_o holds a fresh symbol (registered enc_enable_i)
- enc_d_o  out  2  coded symbol {g1,g0}
- dec_enable_i  in  1  decoder consumes dec_d_i this cycle
- dec_d_i  in  2  received hard symbol {g1,g0}
- dec_valid_o  out  1  dec_d_o holds a decoded bit
- dec_d_o  out  1  decoded information bit

Behaviour:
- Reset (rst low, async): every register clears.
  - enc_valid_o=0, enc_d_o=0, encoder state=00.
  - dec_valid_o=0, dec_d_o=0, survivor registers=0, symbol counter=0.
  - Path metrics: state0=0, states 1..3=8 (forces start in state 0).
- Encoder state {s1,s0}: s1 = previous bit, s0 = bit before that.
  - On enc_enable_i, next cycle: enc_d_o[1]=d^s1^s0 (g=111), enc_d_o[0]=d^s0 (g=101), state <= {d,s1}, enc_valid_o=1.
  - Without enable: enc_valid_o=0, enc_d_o and state hold.
  - Latency 1 cycle.
- Decoder trellis: state index = {s1,s0}. Input bit b moves state {s1,s0} to {b,s1}; expected symbol as in the encoder.
- Each dec_enable_i cycle performs one add-compare-select step for all 4 states:
  - Branch metric = Hamming distance (0..2) between dec_d_i and the expected symbol.
  - Candidate = predecessor metric + branch metric, saturating at 2^METRIC_W-1.
  - Keep the smaller candidate; on a tie keep the predecessor with s0=0.
- Normalization: after ACS, if all four new metrics are ≥ 4, subtract 4 from each. Metrics never wrap.
- Survivor register-exchange:
  - new_path[state] = {path[winning predecessor][TB_DEPTH-2:0], b}, where b = state[1].
  - Decided bit = path[best][TB_DEPTH-1], where best = minimum-metric state using the pre-update metrics; ties go to the lowest index.
- Output update, registered on the same enabled edge:
  - dec_d_o = decided bit.
  - dec_valid_o = 1 once the count of enabled symbols ≥ TB_DEPTH, otherwise 0.
- Net effect: after the n-th enabled symbol (n ≥ TB_DEPTH, 1-based), dec_d_o equals information bit n-TB_DEPTH (0-based).
- dec_enable_i low: metrics, paths and dec_d_o hold; dec_valid_o=0.
- Symbol counter saturates at TB_DEPTH.
- Reset mid-stream abandons all history; decoding restarts from state 0.
- The encoder and decoder paths share no state; they may be enabled on any cycles independently.
- Correction: free distance 5, so any ≤2 symbol-bit errors within a TB_DEPTH window are corrected.

Decomposition:
- Package viterbi_pkg holds:
  - K=3, NUM_STATES=4;
  - generator constants G1=3'b111, G0=3'b101;
  - function expected_symbol(state, bit);
  - initial/normalization metric constants.
- Natural sub-module: conv_encoder, instantiated once in viterbi_codec. Its registers also form the spec's encode path.
- ACS logic stays inline, generate-looped over states.

Test Plan:
- Encoder vector: enable every cycle, bits 1,0,1,1,0,0 from reset -> enc_d_o sequence 11,10,00,01,01,11, with enc_valid_o=1 one cycle after each enable.
- Clean loopback: 256 random bits, enc_d_o registered one cycle into dec_d_i, dec_enable_i=enc_valid_o -> dec_d_o equals input delayed TB_DEPTH symbols, zero mismatches once dec_valid_o=1.
- Single-bit errors: invert dec_d_i[0] on random 1/16 of symbols (N=4) -> zero decoded mismatches.
- Burst of two: invert dec_d_i[0] on two consecutive symbols, bursts ≥ 3*TB_DEPTH apart -> zero decoded mismatches.
- Enable gaps: drop enable for 1-5 cycles at random -> outputs and metrics hold; decoded stream still matches.
- Async reset mid-stream: pull rst low between edges -> all outputs 0 immediately; after release a clean stream decodes correctly with latency TB_DEPTH.
